// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// The datapath substitutes the canonical NOP (addi x0,x0,0 = 32'h0000_0013)
// wherever a bubble is requested.
package pipe_ctrl_pkg;

    localparam int ADDR_WIDTH = 32;

    // Sequencer states: normal flow, fetch outstanding, data memory busy.
    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_IWAIT = 2'b01,
        ST_DWAIT = 2'b10
    } state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Control bundle between the stall/flush sequencer and the datapath/memories.
// ctrl: the sequencer side; dp: the datapath side.
interface pipe_ctrl_if import pipe_ctrl_pkg::*; #(
    parameter int CNT_WIDTH = 32
) ();

    logic [4:0]            id_rs1;
    logic [4:0]            id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [4:0]            ex_rd;
    logic                  ex_mem_read;
    logic                  ex_redirect;
    logic [ADDR_WIDTH-1:0] ex_target;
    logic                  imem_req;
    logic                  imem_ack;
    logic                  dmem_busy;
    logic                  pc_en;
    logic                  if_id_en;
    logic                  if_id_bubble;
    logic                  id_ex_bubble;
    logic                  back_en;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic [CNT_WIDTH-1:0]  stall_cnt;

    modport ctrl (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_redirect, ex_target, imem_ack, dmem_busy,
        output imem_req, pc_en, if_id_en, if_id_bubble, id_ex_bubble,
               back_en, redirect_valid, redirect_pc, stall_cnt
    );

    modport dp (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_redirect, ex_target, imem_ack, dmem_busy,
        input  imem_req, pc_en, if_id_en, if_id_bubble, id_ex_bubble,
               back_en, redirect_valid, redirect_pc, stall_cnt
    );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare: a load in EX writes a register the ID instruction reads.
// Writes to x0 never create a dependency.
module pipe_ctrl_hazard_detect (
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    output logic       load_use
);

    // Combinational source/destination match.
    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Resolves load-use
// hazards, variable-latency fetch, data-memory busy and EX redirects. The only
// data held is the redirect target that arrived while a fetch was outstanding.
module pipe_ctrl import pipe_ctrl_pkg::*; #(
    parameter int CNT_WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    pipe_ctrl_if.ctrl  bus
);

    state_e                state;
    state_e                next_state;
    logic                  pend_valid;
    logic [ADDR_WIDTH-1:0] pend_pc;
    logic [CNT_WIDTH-1:0]  stall_cnt;
    logic                  pend_capture;
    logic                  pend_clear;
    logic                  load_use;

    pipe_ctrl_hazard_detect u_hazard (
        .id_rs1      (bus.id_rs1),
        .id_rs2      (bus.id_rs2),
        .id_use_rs1  (bus.id_use_rs1),
        .id_use_rs2  (bus.id_use_rs2),
        .ex_rd       (bus.ex_rd),
        .ex_mem_read (bus.ex_mem_read),
        .load_use    (load_use)
    );

    assign bus.stall_cnt = stall_cnt;

    // Next state and per-cycle pipeline controls, highest-priority cause first.
    always_comb begin
        // NOTE: every output gets a default before any branch, so no path can infer a latch.
        next_state          = state;
        pend_capture        = 1'b0;
        pend_clear          = 1'b0;
        bus.imem_req        = rst_n && (state != ST_DWAIT);
        bus.pc_en           = 1'b0;
        bus.if_id_en        = 1'b0;
        bus.if_id_bubble    = 1'b1;
        bus.id_ex_bubble    = 1'b1;
        bus.back_en         = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = pend_pc;

        if (rst_n) begin
            if (bus.dmem_busy) begin
                // Full freeze; a redirect held in EX is applied once memory frees up.
                bus.if_id_bubble = 1'b0;
                bus.id_ex_bubble = 1'b0;
                next_state       = ST_DWAIT;
            end else begin
                bus.back_en = 1'b1;
                if (bus.ex_redirect) begin
                    bus.if_id_en = 1'b1;
                    if (bus.imem_ack) begin
                        bus.redirect_valid = 1'b1;
                        bus.redirect_pc    = bus.ex_target;
                        bus.pc_en          = 1'b1;
                        pend_clear         = 1'b1;
                        next_state         = ST_RUN;
                    end else begin
                        pend_capture = 1'b1;
                        next_state   = ST_IWAIT;
                    end
                end else if (load_use) begin
                    // Hold PC and ID, send one bubble down. Leaving DWAIT, the
                    // fetch simply restarts from the held PC.
                    bus.if_id_bubble = 1'b0;
                    next_state       = (state == ST_DWAIT) ? ST_RUN : state;
                end else if (!bus.imem_ack) begin
                    bus.if_id_en     = 1'b1;
                    bus.id_ex_bubble = 1'b0;
                    next_state       = ST_IWAIT;
                end else if (pend_valid) begin
                    // Word fetched down the wrong path: drop it and steer to the target.
                    bus.if_id_en       = 1'b1;
                    bus.id_ex_bubble   = 1'b0;
                    bus.redirect_valid = 1'b1;
                    bus.pc_en          = 1'b1;
                    pend_clear         = 1'b1;
                    next_state         = ST_RUN;
                end else begin
                    bus.pc_en        = 1'b1;
                    bus.if_id_en     = 1'b1;
                    bus.if_id_bubble = 1'b0;
                    bus.id_ex_bubble = 1'b0;
                    next_state       = ST_RUN;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) state <= ST_RUN;
        else        state <= next_state;
    end

    // Pending redirect: the latest target seen while a fetch is outstanding wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_pc    <= '0;
        end else begin
            if (pend_capture) begin
                pend_valid <= 1'b1;
                pend_pc    <= bus.ex_target;
            end else if (pend_clear) begin
                pend_valid <= 1'b0;
            end
        end
    end

    // Saturating count of cycles in which the PC did not advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  stall_cnt <= '0;
        else if (!bus.pc_en && (stall_cnt != '1))    stall_cnt <= stall_cnt + CNT_WIDTH'(1);
    end

    // EX holds a bubble while a redirect is pending, so no second redirect can arrive.
    assert property (@(posedge clk) disable iff (!rst_n) !(pend_valid && bus.ex_redirect));

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: each driven cycle pushes its expected controls,
// a monitor pops and compares them late in the same cycle.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int CW = 4;

    // Expected control vector: {imem_req, pc_en, if_id_en, if_id_bubble,
    //                           id_ex_bubble, back_en, redirect_valid}
    localparam logic [6:0] E_RST      = 7'b0001100;
    localparam logic [6:0] E_ADV      = 7'b1110010;
    localparam logic [6:0] E_LU       = 7'b1000110;
    localparam logic [6:0] E_IW       = 7'b1011010;
    localparam logic [6:0] E_RDR_ACK  = 7'b1111111;
    localparam logic [6:0] E_RDR_NAK  = 7'b1011110;
    localparam logic [6:0] E_PEND_ACK = 7'b1111011;
    localparam logic [6:0] E_FRZ_RUN  = 7'b1000000;
    localparam logic [6:0] E_FRZ_D    = 7'b0000000;
    localparam logic [6:0] E_DEXIT_RD = 7'b0111111;

    typedef struct {
        logic        rst_n;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        use1;
        logic        use2;
        logic [4:0]  ex_rd;
        logic        mem_read;
        logic        redirect;
        logic [31:0] target;
        logic        ack;
        logic        busy;
    } in_t;

    typedef struct {
        string       name;
        logic [6:0]  ctrl;
        logic [31:0] rpc;
        logic [CW-1:0] stall;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    exp_t sb_q[$];
    exp_t mon_e;
    int checks = 0;
    int errors = 0;
    logic [CW-1:0] exp_stall = '0;

    pipe_ctrl_if #(.CNT_WIDTH(CW)) bus ();

    pipe_ctrl #(.CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic in_t idle();
        in_t i;
        i.rst_n    = 1'b1;
        i.rs1      = 5'd0;
        i.rs2      = 5'd0;
        i.use1     = 1'b0;
        i.use2     = 1'b0;
        i.ex_rd    = 5'd0;
        i.mem_read = 1'b0;
        i.redirect = 1'b0;
        i.target   = 32'd0;
        i.ack      = 1'b1;
        i.busy     = 1'b0;
        return i;
    endfunction

    // Drive one cycle of inputs and queue what the sequencer must produce.
    task automatic cyc(input string name, input in_t i, input logic [6:0] ctrl,
                       input logic [31:0] rpc);
        exp_t e;
        @(negedge clk);
        rst_n           = i.rst_n;
        bus.id_rs1      = i.rs1;
        bus.id_rs2      = i.rs2;
        bus.id_use_rs1  = i.use1;
        bus.id_use_rs2  = i.use2;
        bus.ex_rd       = i.ex_rd;
        bus.ex_mem_read = i.mem_read;
        bus.ex_redirect = i.redirect;
        bus.ex_target   = i.target;
        bus.imem_ack    = i.ack;
        bus.dmem_busy   = i.busy;
        if (!i.rst_n) exp_stall = '0;
        e.name  = name;
        e.ctrl  = ctrl;
        e.rpc   = rpc;
        e.stall = exp_stall;
        sb_q.push_back(e);
        if (i.rst_n && !ctrl[5] && (exp_stall != '1)) exp_stall = exp_stall + 1'b1;
    endtask

    // Monitor: compare just before the next rising edge.
    always begin
        @(negedge clk);
        #4;
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            check({mon_e.name, ".ctrl"},
                  {57'd0, bus.imem_req, bus.pc_en, bus.if_id_en, bus.if_id_bubble,
                   bus.id_ex_bubble, bus.back_en, bus.redirect_valid},
                  {57'd0, mon_e.ctrl});
            check({mon_e.name, ".stall"}, 64'(bus.stall_cnt), 64'(mon_e.stall));
            if (mon_e.ctrl[0])
                check({mon_e.name, ".rpc"}, 64'(bus.redirect_pc), 64'(mon_e.rpc));
        end
    end

    initial begin
        in_t i;
        #1 rst_n = 1'b0;

        // Reset state.
        i = idle(); i.rst_n = 1'b0;
        cyc("rst0", i, E_RST, 0);
        cyc("rst1", i, E_RST, 0);

        // Straight-line flow.
        i = idle();
        for (int k = 0; k < 4; k++) cyc("line", i, E_ADV, 0);

        // lw x5 in EX, ID reads x5 via rs2: one bubble then advance.
        i = idle(); i.mem_read = 1'b1; i.ex_rd = 5'd5; i.rs2 = 5'd5; i.use2 = 1'b1;
        cyc("lu_rs2", i, E_LU, 0);
        i = idle();
        cyc("lu_after", i, E_ADV, 0);

        // Load to x0 never stalls; unused matching operand never stalls.
        i = idle(); i.mem_read = 1'b1; i.ex_rd = 5'd0; i.rs1 = 5'd0; i.use1 = 1'b1;
        cyc("lu_x0", i, E_ADV, 0);
        i = idle(); i.mem_read = 1'b1; i.ex_rd = 5'd5; i.rs2 = 5'd5; i.use2 = 1'b0;
        cyc("lu_unused", i, E_ADV, 0);
        i = idle(); i.mem_read = 1'b1; i.ex_rd = 5'd9; i.rs1 = 5'd9; i.use1 = 1'b1;
        cyc("lu_rs1", i, E_LU, 0);
        i = idle();
        cyc("lu_rs1_after", i, E_ADV, 0);

        // Fetch latency of three cycles.
        i = idle(); i.ack = 1'b0;
        for (int k = 0; k < 3; k++) cyc("iwait", i, E_IW, 0);
        i = idle();
        cyc("iwait_ack", i, E_ADV, 0);

        // Redirect during an outstanding fetch; target applied when the fetch returns.
        i = idle(); i.ack = 1'b0;
        cyc("pend_iw", i, E_IW, 0);
        i.redirect = 1'b1; i.target = 32'h100;
        cyc("pend_cap", i, E_RDR_NAK, 0);
        i = idle(); i.ack = 1'b0;
        cyc("pend_wait", i, E_IW, 0);
        i = idle();
        cyc("pend_ack", i, E_PEND_ACK, 32'h100);
        cyc("pend_after", i, E_ADV, 0);

        // Redirect with fetch data available: applied at once.
        i = idle(); i.redirect = 1'b1; i.target = 32'h200;
        cyc("rdr_now", i, E_RDR_ACK, 32'h200);
        i = idle();
        cyc("rdr_after", i, E_ADV, 0);

        // Memory busy for two cycles with a redirect held in EX.
        i = idle(); i.busy = 1'b1; i.redirect = 1'b1; i.target = 32'h300;
        cyc("frz0", i, E_FRZ_RUN, 0);
        cyc("frz1", i, E_FRZ_D, 0);
        i.busy = 1'b0;
        cyc("dexit", i, E_DEXIT_RD, 32'h300);
        i = idle();
        cyc("dexit_after", i, E_ADV, 0);

        // Long fetch stall drives the stall counter into saturation.
        i = idle(); i.ack = 1'b0;
        for (int k = 0; k < 14; k++) cyc("sat", i, E_IW, 0);

        // Reset with a fetch outstanding and a redirect pending: both abandoned.
        i.redirect = 1'b1; i.target = 32'h400;
        cyc("pre_rst", i, E_RDR_NAK, 0);
        i = idle(); i.rst_n = 1'b0; i.ack = 1'b0;
        cyc("mid_rst0", i, E_RST, 0);
        i.ack = 1'b1;
        cyc("mid_rst1", i, E_RST, 0);
        i = idle();
        cyc("post_rst0", i, E_ADV, 0);
        cyc("post_rst1", i, E_ADV, 0);

        @(negedge clk);
        #6;
        check("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
